mm_layer_param_sched: RTL and testbench
=======================================

Name: mm_layer_param_sched

Overview:
- Layer-level scheduler for the matmul+GELU accelerator.
- Takes one shared parameter AXI-Stream and routes it, segment by segment, to NUM_SEG parameter consumers (W_bias, out_m, out_e, W), one register stage per beat.
- Segment lengths are programmable at run time.
- After a layer's parameters are loaded, waits for the accelerator's output-stream TLAST, then advances `layer` until num_layers have completed.

Parameters:
- D_W, 32, stream data width
- NUM_SEG, 4, number of parameter consumers/segments per layer
- LAYERS, 12, maximum layer count
- LEN_W, 16, segment length counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a run (sampled in IDLE only)
- num_layers  in  $clog2(LAYERS+1)  layers in this run, sampled on start
- cfg_we  in  1  length-table write strobe
- cfg_addr  in  $clog2(NUM_SEG)  segment index
- cfg_len  in  LEN_W  segment length in beats (0 = skip segment)
- s_tdata  in  D_W  parameter stream data
- s_tvalid  in  1  parameter stream valid
- s_tready  out  1  parameter stream ready
- m_tdata  out  D_W  routed data, shared by all consumers
- m_tlast  out  1  last beat of current segment
- m_tvalid  out  NUM_SEG  one-hot valid per consumer
- m_tready  in  NUM_SEG  per-consumer ready
- y_tvalid, y_tready, y_tlast  in  1 each  monitor of accelerator output handshake (observe only)
- layer  out  $clog2(LAYERS)  current layer index
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at run end

Behaviour:
- Reset values: state IDLE; layer 0; busy 0; done 0; s_tready 0; m_tvalid 0; m_tlast 0; m_tdata 0; length table all 0; beat counter 0.
- Length table: written when cfg_we=1 in IDLE; cfg_we ignored otherwise. A write takes effect the next cycle.
- States: IDLE, LOAD, WAIT_OUT, DONE.
- IDLE:
  - start=1 and num_layers=0 → DONE.
  - start=1 and num_layers≠0 → latch num_layers, layer←0, cur_seg←lowest index with len≠0, go to LOAD.
  - If every length is 0 → go to WAIT_OUT instead of LOAD.
- LOAD:
  - s_tready = ~out_valid | m_tready[out_seg].
  - On an s handshake: the output register loads data, out_seg←cur_seg, out_last←(cnt==len[cur_seg]−1). cnt increments.
  - On the last beat: cnt←0 and cur_seg←next higher index with len≠0. If there is none → WAIT_OUT.
- Output register:
  - m_tvalid = out_valid ? onehot(out_seg) : 0; m_tlast = out_last.
  - Clears on m_tready[out_seg] unless reloaded the same cycle, so full throughput is 1 beat/cycle.
  - Data is stable while m_tvalid is high and ready is low.
  - Latency s handshake → m_tvalid is 1 cycle.
- WAIT_OUT:
  - s_tready=0, but the output register continues to drain.
  - Layer completes on a y_tvalid&y_tready&y_tlast handshake in WAIT_OUT, provided out_valid=0 in the same cycle. If out_valid=1, the event is latched in a sticky flag and honoured once the register drains.
  - Then: if layer==num_layers−1 → DONE; else layer+1, cur_seg←first nonzero segment, and go to LOAD (or stay in WAIT_OUT if all lengths are 0).
  - y handshakes outside WAIT_OUT are ignored; the sticky flag clears on leaving WAIT_OUT.
- DONE: done=1 for exactly one cycle, then IDLE. layer holds its final value until the next start.
- busy = (state≠IDLE).
- start while busy: ignored.
- num_layers > LAYERS: clamped to LAYERS.
- Reset mid-operation: all state returns to the reset values in the next cycle. A partially delivered segment is abandoned and no m_tlast is issued.

Decomposition:
- Package mm_sched_pkg:
  - state enum {IDLE, LOAD, WAIT_OUT, DONE}
  - segment index constants SEG_W_BIAS=0, SEG_OUT_M=1, SEG_OUT_E=2, SEG_W=3
  - default NUM_SEG
- Sub-module axis_route_reg:
  - one-entry output register with data/last/seg and valid/ready logic
  - instantiated once; FSM, counters and length table stay in the top module.

Test Plan:
- Lengths {3,2,1,4}, num_layers=1, all ready high, s_tvalid continuous → 10 beats accepted back-to-back; m_tvalid one-hot 0001×3, 0010×2, 0100×1, 1000×4; m_tlast on beats 3, 5, 6, 10; after a y TLAST handshake, done pulses once, busy falls, layer=0.
- Lengths {2,0,0,1}, num_layers=3 → segments 1 and 2 are never asserted; layer steps 0→1→2 after each y TLAST; done follows the third y TLAST; a y TLAST injected during LOAD does not advance layer.
- Backpressure: m_tready[0] low for 4 cycles mid-segment → s_tready low after the register fills; m_tdata held stable; no beat lost or duplicated (scoreboard checks order 0..N).
- y TLAST handshake arriving while the final W beat is still in the output register (m_tready[3]=0) → layer advances only after that beat drains, one cycle later at the earliest.
- num_layers=0 and start → done pulses 2 cycles later, no s_tready. All lengths 0 with num_layers=2 → two y TLASTs produce done.
- rst_n low for 1 cycle mid-segment (cnt=2) → next cycle m_tvalid=0, layer=0, busy=0; a new start restarts at segment 0 beat 0. cfg_we while busy leaves the table unchanged.

Source files
------------

// File: rtl/mm_sched_pkg.sv
// rtl/mm_sched_pkg.sv - shared types and constants for the layer parameter scheduler
package mm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_OUT = 2'd2,
    DONE     = 2'd3
  } sched_state_e;

  localparam int SEG_W_BIAS      = 0;
  localparam int SEG_OUT_M       = 1;
  localparam int SEG_OUT_E       = 2;
  localparam int SEG_W           = 3;
  localparam int DEFAULT_NUM_SEG = 4;

endpackage

// File: rtl/axis_route_reg.sv
// rtl/axis_route_reg.sv - one-entry routed output register with per-consumer valid
module axis_route_reg #(
  parameter  int D_W     = 32,
  parameter  int NUM_SEG = 4,
  localparam int SEG_IW  = $clog2(NUM_SEG)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [D_W-1:0]     data_i,
  input  logic               last_i,
  input  logic [SEG_IW-1:0]  seg_i,
  input  logic [NUM_SEG-1:0] m_tready_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [D_W-1:0]     m_tdata_o,
  output logic               m_tlast_o,
  output logic [NUM_SEG-1:0] m_tvalid_o
);

  logic              valid_q;
  logic [D_W-1:0]    data_q;
  logic              last_q;
  logic [SEG_IW-1:0] seg_q;
  logic              drain;

  // Only the consumer currently addressed can drain the entry.
  assign drain   = valid_q & m_tready_i[seg_q];
  assign ready_o = ~valid_q | m_tready_i[seg_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      seg_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
      seg_q   <= seg_i;
    end else if (drain) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign valid_o    = valid_q;
  assign m_tdata_o  = data_q;
  assign m_tlast_o  = last_q;
  assign m_tvalid_o = valid_q ? (NUM_SEG'(1) << seg_q) : '0;

endmodule

// File: rtl/mm_layer_param_sched.sv
// rtl/mm_layer_param_sched.sv - routes the shared parameter stream to per-segment consumers, layer by layer
module mm_layer_param_sched
  import mm_sched_pkg::*;
#(
  parameter  int D_W     = 32,
  parameter  int NUM_SEG = DEFAULT_NUM_SEG,
  parameter  int LAYERS  = 12,
  parameter  int LEN_W   = 16,
  localparam int NL_W    = $clog2(LAYERS + 1),
  localparam int LYR_W   = $clog2(LAYERS),
  localparam int SEG_IW  = $clog2(NUM_SEG)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NL_W-1:0]    num_layers,
  input  logic               cfg_we,
  input  logic [SEG_IW-1:0]  cfg_addr,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [D_W-1:0]     s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  output logic [D_W-1:0]     m_tdata,
  output logic               m_tlast,
  output logic [NUM_SEG-1:0] m_tvalid,
  input  logic [NUM_SEG-1:0] m_tready,
  input  logic               y_tvalid,
  input  logic               y_tready,
  input  logic               y_tlast,
  output logic [LYR_W-1:0]   layer,
  output logic               busy,
  output logic               done
);

  sched_state_e      state_q, state_d;
  logic [LEN_W-1:0]  len_q [NUM_SEG];
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [SEG_IW-1:0] cur_seg_q, cur_seg_d;
  logic [LYR_W-1:0]  layer_q, layer_d;
  logic [NL_W-1:0]   nl_q, nl_d;
  logic              sticky_q, sticky_d;

  logic [NUM_SEG-1:0] nz;
  logic               first_found, next_found;
  logic [SEG_IW-1:0]  first_idx, next_idx;
  logic [NL_W-1:0]    nl_clamped;
  logic               rr_ready, out_valid, s_hs, y_hs, beat_last, last_layer;

  // Lowest nonzero segment overall, and lowest nonzero segment above the current one.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_SEG - 1; i >= 0; i--) begin
      nz[i] = (len_q[i] != '0);
      if (nz[i]) begin
        first_found = 1'b1;
        first_idx   = SEG_IW'(i);
      end
      if (nz[i] && (i > int'(cur_seg_q))) begin
        next_found = 1'b1;
        next_idx   = SEG_IW'(i);
      end
    end
  end

  assign nl_clamped = (num_layers > NL_W'(LAYERS)) ? NL_W'(LAYERS) : num_layers;
  assign s_tready   = (state_q == LOAD) & rr_ready;
  assign s_hs       = s_tvalid & s_tready;
  assign y_hs       = y_tvalid & y_tready & y_tlast;
  assign beat_last  = (cnt_q == (len_q[cur_seg_q] - LEN_W'(1)));
  assign last_layer = ((NL_W'(layer_q) + NL_W'(1)) == nl_q);

  axis_route_reg #(
    .D_W     (D_W),
    .NUM_SEG (NUM_SEG)
  ) u_route (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (s_hs),
    .data_i     (s_tdata),
    .last_i     (beat_last),
    .seg_i      (cur_seg_q),
    .m_tready_i (m_tready),
    .ready_o    (rr_ready),
    .valid_o    (out_valid),
    .m_tdata_o  (m_tdata),
    .m_tlast_o  (m_tlast),
    .m_tvalid_o (m_tvalid)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_seg_d = cur_seg_q;
    layer_d   = layer_q;
    nl_d      = nl_q;
    sticky_d  = sticky_q;
    unique case (state_q)
      IDLE: begin
        sticky_d = 1'b0;
        if (start) begin
          if (nl_clamped == '0) begin
            state_d = DONE;
          end else begin
            nl_d      = nl_clamped;
            layer_d   = '0;
            cnt_d     = '0;
            cur_seg_d = first_idx;
            state_d   = first_found ? LOAD : WAIT_OUT;
          end
        end
      end
      LOAD: begin
        if (s_hs) begin
          if (beat_last) begin
            cnt_d = '0;
            if (next_found) cur_seg_d = next_idx;
            else            state_d   = WAIT_OUT;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      WAIT_OUT: begin
        // An output TLAST seen while a beat is still pending is held until it drains.
        if ((y_hs | sticky_q) && !out_valid) begin
          sticky_d = 1'b0;
          if (last_layer) begin
            state_d = DONE;
          end else begin
            layer_d   = layer_q + LYR_W'(1);
            cnt_d     = '0;
            cur_seg_d = first_idx;
            state_d   = first_found ? LOAD : WAIT_OUT;
          end
        end else if (y_hs) begin
          sticky_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_seg_q <= '0;
      layer_q   <= '0;
      nl_q      <= '0;
      sticky_q  <= 1'b0;
      for (int i = 0; i < NUM_SEG; i++) len_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_seg_q <= cur_seg_d;
      layer_q   <= layer_d;
      nl_q      <= nl_d;
      sticky_q  <= sticky_d;
      if (cfg_we && (state_q == IDLE)) len_q[cfg_addr] <= cfg_len;
    end
  end

  assign layer = layer_q;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_mm_layer_param_sched.sv
// tb/tb_mm_layer_param_sched.sv - self-checking bench for mm_layer_param_sched
module tb_mm_layer_param_sched;
  import mm_sched_pkg::*;

  localparam int D_W = 32;
  localparam int NS  = 4;
  localparam int LAYERS = 12;

  logic          clk = 1'b0;
  logic          rst_n, start, cfg_we, s_tvalid, s_tready, m_tlast;
  logic [3:0]    num_layers, m_tvalid, m_tready, layer;
  logic [1:0]    cfg_addr;
  logic [15:0]   cfg_len;
  logic [D_W-1:0] s_tdata, m_tdata;
  logic          y_tvalid, y_tready, y_tlast, busy, done;

  always #5 clk = ~clk;

  mm_layer_param_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_layers(num_layers),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .y_tvalid(y_tvalid), .y_tready(y_tready), .y_tlast(y_tlast),
    .layer(layer), .busy(busy), .done(done)
  );

  int checks = 0;
  int failures = 0;

  // Reference: expected beat list per run, and what the bench observed.
  logic [D_W-1:0] data_a[$];
  int             exp_seg[$];
  bit             exp_last[$];
  logic [D_W-1:0] obs_data[$];
  logic [3:0]     obs_v[$];
  bit             obs_last[$];

  int sent, rcv, ydone, cyc, done_cnt, done_cyc, viol, hs_first, hs_last, hs_n, bp_cnt, ph;
  bit sready_seen;
  logic [3:0] seen_mask;

  task automatic idle_inputs();
    start = 0; num_layers = '0; cfg_we = 0; cfg_addr = '0; cfg_len = '0;
    s_tvalid = 0; s_tdata = '0; m_tready = '0;
    y_tvalid = 0; y_tready = 0; y_tlast = 0;
  endtask

  // mode 0: all ready, continuous valid; 1: random; 2: stall segment 0; 3: TLAST while final beat held
  task automatic run_case(input int l0, input int l1, input int l2, input int l3,
                          input int nl_in, input int mode, input bit inject, input string name);
    int lens[4];
    int nl, p, hold, stall_left, tail;
    bit prev_hold, injected, stalled, fin;
    logic [D_W-1:0] pd;
    logic [3:0] pv, exp_mask, eo;
    logic pl;
    lens = '{l0, l1, l2, l3};
    nl = (nl_in > LAYERS) ? LAYERS : nl_in;
    p = l0 + l1 + l2 + l3;
    data_a.delete(); exp_seg.delete(); exp_last.delete();
    obs_data.delete(); obs_v.delete(); obs_last.delete();
    exp_mask = '0;
    for (int l = 0; l < nl; l++)
      for (int s = 0; s < NS; s++)
        for (int b = 0; b < lens[s]; b++) begin
          exp_seg.push_back(s);
          exp_last.push_back(b == lens[s] - 1);
          exp_mask[s] = 1'b1;
        end
    for (int k = 0; k < p * nl; k++) data_a.push_back($urandom);

    for (int s = 0; s < NS; s++) begin
      @(posedge clk); #1;
      cfg_we = 1; cfg_addr = 2'(s); cfg_len = 16'(lens[s]);
    end
    @(posedge clk); #1;
    cfg_we = 0; start = 1; num_layers = 4'(nl_in);

    sent = 0; rcv = 0; ydone = 0; cyc = 0; done_cnt = 0; done_cyc = 0; viol = 0;
    hs_first = 0; hs_last = 0; hs_n = 0; bp_cnt = 0; ph = 0; sready_seen = 0; seen_mask = '0;
    prev_hold = 0; injected = 0; stalled = 0; stall_left = 0; hold = 0; tail = 0; fin = 0;
    pd = '0; pv = '0; pl = 0;

    while (!fin && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start = 0;
      // Table writes while busy must be ignored.
      cfg_we = (cyc == 1); cfg_addr = 2'd0; cfg_len = 16'($urandom_range(1, 9));
      s_tvalid = (sent < data_a.size()) && (mode != 1 || $urandom_range(0, 3) != 0);
      s_tdata  = (sent < data_a.size()) ? data_a[sent] : $urandom;
      case (mode)
        1: m_tready = 4'($urandom);
        2: begin
          if (!stalled && rcv == 2) begin stalled = 1; stall_left = 4; end
          if (stall_left > 0) begin m_tready = ~(4'b1 << SEG_W_BIAS); stall_left--; end
          else m_tready = '1;
        end
        3: begin
          if (ph == 0) m_tready = (rcv == p - 1) ? ~(4'b1 << SEG_W) : 4'hF;
          else if (ph == 1 || ph == 2) m_tready = ~(4'b1 << SEG_W);
          else m_tready = '1;
        end
        default: m_tready = '1;
      endcase
      y_tvalid = 0; y_tready = 1'($urandom); y_tlast = 0;
      if (mode == 1 && $urandom_range(0, 3) == 0) begin
        y_tvalid = 1;
        if ($urandom_range(0, 1) == 1) begin y_tlast = 1; y_tready = 0; end
        else begin y_tlast = 0; y_tready = 1; end
      end
      if (inject && !injected && sent > 0 && sent < p) begin
        y_tvalid = 1; y_tready = 1; y_tlast = 1; injected = 1;
      end
      if (mode == 3 && ph == 1) begin
        checks++;
        if (layer !== 4'd0) begin failures++; $display("FAIL %s y_held_layer got=%0d want=0", name, layer); end
        y_tvalid = 1; y_tready = 1; y_tlast = 1; ydone = 1; hold = 2;
      end else if (mode == 3 && ph == 2) begin
        hold--;
      end else if (!(mode == 3 && ph < 6) && ydone < nl && rcv == (ydone + 1) * p) begin
        checks++;
        if (layer !== 4'(ydone)) begin failures++; $display("FAIL %s layer_at_y got=%0d want=%0d", name, layer, ydone); end
        y_tvalid = 1; y_tready = 1; y_tlast = 1; ydone++;
      end

      @(negedge clk);
      if (s_tvalid && s_tready) begin
        if (hs_n == 0) hs_first = cyc;
        hs_last = cyc; hs_n++; sent++;
      end
      if (s_tready) sready_seen = 1;
      if (!$onehot0(m_tvalid)) viol++;
      if (prev_hold && (m_tvalid !== pv || m_tdata !== pd || m_tlast !== pl)) viol++;
      if (((m_tvalid & ~m_tready) != 0) && s_tready) viol++;
      if (mode == 2 && stalled && !m_tready[SEG_W_BIAS] && !s_tready) bp_cnt++;
      seen_mask |= m_tvalid;
      prev_hold = (m_tvalid != 0) && ((m_tvalid & m_tready) == 0);
      pv = m_tvalid; pd = m_tdata; pl = m_tlast;
      case (ph)
        0: if (mode == 3 && m_tvalid[SEG_W] && !m_tready[SEG_W] && rcv == p - 1) ph = 1;
        1: ph = 2;
        2, 3, 4, 5: begin
          checks++;
          if (layer !== ((ph == 5) ? 4'd1 : 4'd0)) begin
            failures++; $display("FAIL %s drain_then_advance ph=%0d layer=%0d", name, ph, layer);
          end
          if (ph != 2 || hold == 0) ph++;
        end
        default: ;
      endcase
      if ((m_tvalid & m_tready) != 0) begin
        obs_data.push_back(m_tdata); obs_v.push_back(m_tvalid); obs_last.push_back(m_tlast);
        rcv++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
      end
      if (done_cnt > 0) tail++;
      fin = (tail >= 3);
    end

    checks++;
    if (!fin) begin failures++; $display("FAIL %s timeout cycles=%0d done_cnt=%0d", name, cyc, done_cnt); end
    checks++;
    if (obs_v.size() != exp_seg.size()) begin
      failures++; $display("FAIL %s beat_count got=%0d want=%0d", name, obs_v.size(), exp_seg.size());
    end
    for (int i = 0; i < obs_v.size() && i < exp_seg.size(); i++) begin
      eo = 4'b1 << exp_seg[i];
      checks++;
      if (obs_v[i] !== eo || obs_data[i] !== data_a[i] || obs_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL %s beat%0d got v=%b d=%h l=%b want v=%b d=%h l=%b", name, i,
                 obs_v[i], obs_data[i], obs_last[i], eo, data_a[i], exp_last[i]);
      end
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL %s protocol violations=%0d want=0", name, viol); end
    checks++;
    if (seen_mask !== exp_mask) begin failures++; $display("FAIL %s seg_mask got=%b want=%b", name, seen_mask, exp_mask); end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL %s done_pulses got=%0d want=1", name, done_cnt); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_after got=%b want=0", name, busy); end
    if (nl > 0) begin
      checks++;
      if (layer !== 4'(nl - 1)) begin failures++; $display("FAIL %s final_layer got=%0d want=%0d", name, layer, nl - 1); end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 0 || done !== 0 || s_tready !== 0 || m_tvalid !== 4'd0 || m_tlast !== 0 ||
        m_tdata !== '0 || layer !== 4'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b s_tready=%b m_tvalid=%b m_tlast=%b m_tdata=%h layer=%0d want all zero",
               busy, done, s_tready, m_tvalid, m_tlast, m_tdata, layer);
    end
  endtask

  task automatic test_single_layer();
    run_case(3, 2, 1, 4, 1, 0, 0, "single");
    checks++;
    if (hs_n != 10 || hs_last - hs_first != 9) begin
      failures++; $display("FAIL single back_to_back got n=%0d span=%0d want n=10 span=9", hs_n, hs_last - hs_first);
    end
  endtask

  task automatic test_multi_layer();
    run_case(2, 0, 0, 1, 3, 0, 1, "multi");
    checks++;
    if (seen_mask[SEG_OUT_M] !== 1'b0 || seen_mask[SEG_OUT_E] !== 1'b0) begin
      failures++; $display("FAIL multi skipped_segs got=%b want=0", {seen_mask[SEG_OUT_E], seen_mask[SEG_OUT_M]});
    end
  endtask

  task automatic test_backpressure();
    run_case(6, 2, 1, 3, 1, 2, 0, "backpressure");
    checks++;
    if (bp_cnt != 4) begin failures++; $display("FAIL backpressure s_tready_low_cycles got=%0d want=4", bp_cnt); end
  endtask

  task automatic test_y_during_drain();
    run_case(1, 0, 0, 2, 2, 3, 0, "y_drain");
    checks++;
    if (ph != 6) begin failures++; $display("FAIL y_drain sequence got=%0d want=6", ph); end
  endtask

  task automatic test_zero_layers();
    run_case(2, 1, 1, 1, 0, 0, 0, "zero_layers");
    checks++;
    if (done_cyc < 1 || done_cyc > 2 || sready_seen) begin
      failures++; $display("FAIL zero_layers done_cyc=%0d sready=%b want 1..2 and 0", done_cyc, sready_seen);
    end
    run_case(0, 0, 0, 0, 2, 0, 0, "all_zero_len");
  endtask

  task automatic test_clamp();
    run_case(1, 0, 0, 0, 14, 0, 0, "clamp");
  endtask

  task automatic test_reset_mid();
    int n, guard;
    for (int s = 0; s < NS; s++) begin
      @(posedge clk); #1;
      cfg_we = 1; cfg_addr = 2'(s); cfg_len = (s == 0) ? 16'd4 : 16'd1;
    end
    @(posedge clk); #1;
    cfg_we = 0; start = 1; num_layers = 4'd1;
    n = 0; guard = 0;
    while (n < 2 && guard < 20) begin
      @(posedge clk); #1;
      start = 0; s_tvalid = 1; s_tdata = $urandom; m_tready = '1; guard++;
      @(negedge clk);
      if (s_tvalid && s_tready) n++;
    end
    @(posedge clk); #1;
    rst_n = 0; s_tvalid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    checks++;
    if (n != 2 || m_tvalid !== 4'd0 || m_tlast !== 0 || layer !== 4'd0 || busy !== 0 || s_tready !== 0) begin
      failures++;
      $display("FAIL reset_mid beats=%0d m_tvalid=%b m_tlast=%b layer=%0d busy=%b s_tready=%b want 2,0,0,0,0,0",
               n, m_tvalid, m_tlast, layer, busy, s_tready);
    end
    idle_inputs();
    run_case(3, 1, 0, 2, 1, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++)
      run_case($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(1, 13), 1, 0, "random");
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1;
    test_single_layer();
    test_multi_layer();
    test_backpressure();
    test_y_during_drain();
    test_zero_layers();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
